quad_decoder_counter: RTL
=========================

Name: quad_decoder_counter

Overview:
- Quadrature (A/B) decoder with an integrated up/down position counter.
- Decodes incremental-encoder phase signals into step/direction events and accumulates them in a loadable, wrapping counter.
- Sits at the off-chip encoder interface and feeds position to downstream logic.
- Asynchronous phase inputs are synchronized internally; illegal transitions are flagged.

Parameters:
- WIDTH, 4, counter and load-data width in bits.
- SYNC_STAGES, 2, synchronizer flop depth per phase input (minimum 2).

Ports:
- clock  input  1  system clock; all logic on posedge.
- rst  input  1  reset, synchronous, active-high.
- a_in  input  1  encoder phase A, asynchronous.
- b_in  input  1  encoder phase B, asynchronous.
- load  input  1  load din into counter.
- din  input  WIDTH  load value.
- err_clr  input  1  clear sticky error flag.
- dout  output  WIDTH  position count.
- dir  output  1  direction of last valid step: 1 = up, 0 = down.
- step  output  1  one-cycle pulse per counted step.
- ovf  output  1  one-cycle pulse when an up step wraps max to 0.
- unf  output  1  one-cycle pulse when a down step wraps 0 to max.
- err  output  1  sticky illegal-transition flag.

Behaviour:
- Reset: rst high at an edge forces:
  - dout=0, dir=0, step=0, ovf=0, unf=0, err=0.
  - All synchronizer flops and the previous-state register to 00.
  - The prime counter to 0.
- Synchronizer: a_in and b_in each pass through SYNC_STAGES flops. The decoded state is s = {a_sync, b_sync}.
- Priming: for SYNC_STAGES+1 cycles after rst deasserts:
  - prev tracks s.
  - No step, error, or count is produced.
  - The primed flag then sets and stays set until the next rst.
- Decode (primed, each cycle, prev vs s):
  - Up (A leads): 00→10, 10→11, 11→01, 01→00.
  - Down: 00→01, 01→11, 11→10, 10→00.
  - s == prev: no action.
  - Both bits changed (00↔11, 10↔01): illegal. Set err; no count; dir unchanged.
  - prev <= s every cycle.
- Priority each edge: rst > load > valid step.
  - load: dout <= din. Any simultaneous step is discarded: no step/ovf/unf pulse, dir unchanged.
  - Valid up step: dout <= dout+1 mod 2^WIDTH; dir=1; step=1; ovf=1 iff old dout = 2^WIDTH-1.
  - Valid down step: dout <= dout-1 mod 2^WIDTH; dir=0; step=1; unf=1 iff old dout = 0.
  - Otherwise dout holds.
- step, ovf, and unf are registered and high for exactly one cycle per event.
- Latency: an a_in/b_in change meeting setup before edge N updates dout/step at edge N+SYNC_STAGES.
- err is sticky:
  - err_clr clears it.
  - If err_clr and a new illegal transition occur in the same cycle, err stays 1.
  - An illegal transition concurrent with load still sets err.
- Reset mid-operation: takes effect at the next edge regardless of state. Re-priming prevents a spurious step or error from encoder levels held at reset.
- Max one step per cycle. Encoder edge rate must be below clock/(SYNC_STAGES+1); faster input yields illegal transitions, which are flagged, not miscounted silently.

Decomposition:
- Package quad_pkg:
  - Phase-state constants ST_00, ST_01, ST_10, ST_11.
  - Direction constants DIR_UP=1, DIR_DN=0.
  - Decode-result enum {NONE, UP, DOWN, ILLEGAL}.
  - Function decode(prev, cur) returning the enum.
- Sub-module sync_ff (parameter STAGES, 1-bit, synchronous reset to 0), instantiated twice: A and B.
- Counter and flags stay in the top module.

Test Plan:
1. WIDTH=4, SYNC_STAGES=2. Reset with a=b=0, wait 4 cycles, then drive 00→10→11→01→00, holding each state 4 cycles → dout 1,2,3,4; dir=1; four single-cycle step pulses, each 2 edges after the input change; err=0.
2. load=1 with din=4'hE for one cycle, then 2 up steps → dout E, F, then 0 with ovf pulse coincident with step. One more step → dout 1, ovf=0.
3. After reset (dout=0), drive 00→01 → dout=F, unf=1 for one cycle, dir=0. Then 01→11 → dout=E.
4. Drive 00→11 directly → err=1, dout unchanged, no step. Pulse err_clr → err=0. Then illegal 11→00 in the same cycle as err_clr → err remains 1.
5. Time load (din=4'h7) to the same edge a valid up step decodes → dout=7, no step pulse. The next valid up step → dout=8.
6. Count to 5, assert rst for 1 cycle while a=b=1 held, release → dout=0, err=0, no step during priming. A subsequent 11→01 → dout=1.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared phase-state constants and the quadrature transition decoder
// used by the position counter.
package quad_pkg;

  localparam logic [1:0] ST_00 = 2'b00;
  localparam logic [1:0] ST_01 = 2'b01;
  localparam logic [1:0] ST_10 = 2'b10;
  localparam logic [1:0] ST_11 = 2'b11;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [1:0] {NONE, UP, DOWN, ILLEGAL} dec_t;

  // Phase state is {A, B}; A leading B counts up.
  function automatic dec_t decode(input logic [1:0] prev, input logic [1:0] cur);
    dec_t res;
    res = NONE;
    if (prev == cur) begin
      res = NONE;
    end else if ((prev ^ cur) == 2'b11) begin
      res = ILLEGAL;
    end else begin
      unique case (prev)
        ST_00:   res = (cur == ST_10) ? UP : DOWN;
        ST_10:   res = (cur == ST_11) ? UP : DOWN;
        ST_11:   res = (cur == ST_01) ? UP : DOWN;
        default: res = (cur == ST_00) ? UP : DOWN;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for one asynchronous bit, synchronously
// cleared so the decoder starts from a known 00 phase state.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clock) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/quad_decoder_counter.sv
// Quadrature decoder feeding a loadable, wrapping up/down position counter
// with step/overflow/underflow pulses and a sticky illegal-transition flag.
module quad_decoder_counter
  import quad_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             err_clr,
  output logic [WIDTH-1:0] dout,
  output logic             dir,
  output logic             step,
  output logic             ovf,
  output logic             unf,
  output logic             err
);

  localparam int PW = $clog2(SYNC_STAGES + 2);

  logic          a_sync;
  logic          b_sync;
  logic [1:0]    s;
  logic [1:0]    prev;
  logic [PW-1:0] prime_cnt;
  logic          primed;
  dec_t          res;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_a (
    .clock (clock),
    .rst   (rst),
    .d     (a_in),
    .q     (a_sync)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_b (
    .clock (clock),
    .rst   (rst),
    .d     (b_in),
    .q     (b_sync)
  );

  assign s = {a_sync, b_sync};

  always_comb begin
    res = NONE;
    if (primed) res = decode(prev, s);
  end

  // Decoding stays off until the synchronizers have flushed levels held at reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      prev      <= ST_00;
      prime_cnt <= '0;
      primed    <= 1'b0;
    end else begin
      prev <= s;
      if (!primed) begin
        if (prime_cnt == PW'(SYNC_STAGES)) primed <= 1'b1;
        else prime_cnt <= prime_cnt + PW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      dout <= '0;
      dir  <= DIR_DN;
      step <= 1'b0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
    end else begin
      step <= 1'b0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
      if (load) begin
        dout <= din;
      end else if (res == UP) begin
        dout <= dout + WIDTH'(1);
        dir  <= DIR_UP;
        step <= 1'b1;
        ovf  <= (dout == {WIDTH{1'b1}});
      end else if (res == DOWN) begin
        dout <= dout - WIDTH'(1);
        dir  <= DIR_DN;
        step <= 1'b1;
        unf  <= (dout == '0);
      end
    end
  end

  // A new illegal transition wins over a simultaneous clear.
  always_ff @(posedge clock) begin
    if (rst) begin
      err <= 1'b0;
    end else if (res == ILLEGAL) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

endmodule
